// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: sequencing states,
// default datapath width and the quotient reported on divide-by-zero.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIV_WIDTH = 32;

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, restore on borrow.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] next_rem,
   output logic [WIDTH-1:0] next_q
);

   logic [WIDTH:0] a;
   logic [WIDTH:0] nb;
   logic [WIDTH:0] trial;
   logic           borrow;

   assign a  = {rem, q[WIDTH-1]};
   assign nb = ~{1'b0, divisor};

   // a + ~b + 1 as an explicit ripple chain; bit WIDTH of the result is the borrow
   always_comb begin : ripple
      logic c;
      c     = 1'b1;
      trial = '0;
      for (int i = 0; i <= WIDTH; i++) begin
         trial[i] = a[i] ^ nb[i] ^ c;
         c        = (a[i] & nb[i]) | (c & (a[i] ^ nb[i]));
      end
   end

   assign borrow   = trial[WIDTH];
   assign next_q   = {q[WIDTH-2:0], ~borrow};
   assign next_rem = borrow ? {rem[WIDTH-2:0], q[WIDTH-1]} : trial[WIDTH-1:0];

endmodule

// File: rtl/divider_ctrl.sv
// Sequencing controller for the unsigned restoring divider: start/busy/done
// handshake, step counter, working registers and registered results.
module divider_ctrl
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] next_rem;
   logic [WIDTH-1:0] next_q;
   logic             accept;
   logic             last_step;

   assign accept    = (state == IDLE) && start;
   assign last_step = (state == RUN) && (count == CNT_W'(1));

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .q        (q),
      .divisor  (dvs),
      .next_rem (next_rem),
      .next_q   (next_q)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (divisor == '0) ? DONE : RUN;
         RUN:     if (count == CNT_W'(1)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Working registers carry no reset: they are always reloaded on acceptance.
   always_ff @(posedge clk) begin
      if (accept) begin
         dvs <= divisor;
         rem <= '0;
         q   <= dividend;
      end else if (state == RUN) begin
         rem <= next_rem;
         q   <= next_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         if (divisor != '0) begin
            count       <= CNT_W'(WIDTH);
            div_by_zero <= 1'b0;
         end else begin
            quotient    <= WIDTH'(DIV_ZERO_QUOT);
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end
      end else if (state == RUN) begin
         count <= count - CNT_W'(1);
         if (last_step) begin
            quotient  <= next_q;
            remainder <= next_rem;
         end
      end
   end

endmodule

// File: tb/tb_divider_ctrl.sv
// Bench for divider_ctrl: timeline model of accepted operations checked every
// cycle, plus directed operations with hand-computed results and latencies.
module tb_divider_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   divider_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Model: an accepted op at edge k finishes at edge d (k for /0, k+W otherwise);
   // the next op can be accepted from edge d+2.
   int           e = 0;
   int           k = 0;
   int           d = -1;
   int           free_at = 0;
   bit           active = 0;
   logic [W-1:0] pend_q = '0;
   logic [W-1:0] pend_r = '0;
   bit           pend_z = 0;
   logic [W-1:0] m_q = '0;
   logic [W-1:0] m_r = '0;
   bit           m_z = 0;
   bit           m_busy = 0;
   bit           m_done = 0;

   always @(posedge clk) begin
      e++;
      if (rst) begin
         active  = 0;
         free_at = e + 1;
         m_q     = '0;
         m_r     = '0;
         m_z     = 0;
      end else begin
         if (e >= free_at && start) begin
            k      = e;
            active = 1;
            if (divisor == 0) begin
               d      = k;
               pend_q = 32'hFFFF_FFFF;
               pend_r = dividend;
               pend_z = 1;
            end else begin
               d      = k + W;
               pend_q = dividend / divisor;
               pend_r = dividend % divisor;
               pend_z = 0;
               m_z    = 0;
            end
            free_at = d + 2;
         end
         if (active && e == d) begin
            m_q = pend_q;
            m_r = pend_r;
            m_z = pend_z;
         end
      end
      m_busy = active && !pend_z && (e >= k) && (e < d);
      m_done = active && (e == d);
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (e >= 1) begin
         chk("busy", W'(busy), W'(m_busy));
         chk("done", W'(done), W'(m_done));
         chk("quotient", quotient, m_q);
         chk("remainder", remainder, m_r);
         chk("div_by_zero", W'(div_by_zero), W'(m_z));
      end
   end

   // Issue one op; lat = negedge samples from the start edge to the done sample.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat, output int bcnt);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      bcnt  = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      if (lat >= 100) begin
         checks++;
         errors++;
         $display("FAIL timeout waiting for done: %0d cycles, required under 100", lat);
      end
      q = quotient;
      r = remainder;
      z = div_by_zero;
   endtask

   logic [W-1:0] rq, rr;
   logic         rz;
   int           lat, bcnt;

   initial begin
      repeat (2) @(negedge clk);
      chk("reset busy", W'(busy), 0);
      chk("reset done", W'(done), 0);
      chk("reset quotient", quotient, 0);
      chk("reset remainder", remainder, 0);
      rst = 1'b0;

      run_op(100, 7, rq, rr, rz, lat, bcnt);
      chk("100/7 q", rq, 14);
      chk("100/7 r", rr, 2);
      chk("100/7 dbz", W'(rz), 0);
      chk("100/7 latency", W'(lat), 33);
      chk("100/7 busy cycles", W'(bcnt), 32);

      run_op(32'hFFFF_FFFF, 1, rq, rr, rz, lat, bcnt);
      chk("max/1 q", rq, 32'hFFFF_FFFF);
      chk("max/1 r", rr, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, rq, rr, rz, lat, bcnt);
      chk("max/max q", rq, 1);
      chk("max/max r", rr, 0);
      run_op(5, 9, rq, rr, rz, lat, bcnt);
      chk("5/9 q", rq, 0);
      chk("5/9 r", rr, 5);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, rq, rr, rz, lat, bcnt);
      chk("msb/max q", rq, 0);
      chk("msb/max r", rr, 32'h8000_0000);

      run_op(1234, 0, rq, rr, rz, lat, bcnt);
      chk("1234/0 q", rq, 32'hFFFF_FFFF);
      chk("1234/0 r", rr, 1234);
      chk("1234/0 dbz", W'(rz), 1);
      chk("1234/0 latency", W'(lat), 1);
      @(negedge clk);
      chk("dbz holds in idle", W'(div_by_zero), 1);
      run_op(10, 3, rq, rr, rz, lat, bcnt);
      chk("10/3 q", rq, 3);
      chk("10/3 r", rr, 1);
      chk("10/3 dbz cleared", W'(rz), 0);

      // start during RUN is ignored
      @(negedge clk);
      dividend = 100; divisor = 7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      dividend = 9; divisor = 2; start = 1'b1;
      @(negedge clk);
      start = 1'b0; dividend = 77; divisor = 5;
      lat = 0;
      while (!done && lat < 100) begin @(negedge clk); lat++; end
      chk("ignored start q", quotient, 14);
      chk("ignored start r", remainder, 2);

      // reset mid-run discards the op
      @(negedge clk);
      dividend = 100; divisor = 7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid-run rst busy", W'(busy), 0);
      chk("mid-run rst done", W'(done), 0);
      chk("mid-run rst quotient", quotient, 0);
      chk("mid-run rst remainder", remainder, 0);
      repeat (30) @(negedge clk);
      run_op(50, 6, rq, rr, rz, lat, bcnt);
      chk("50/6 q", rq, 8);
      chk("50/6 r", rr, 2);

      // back-to-back with start held high
      @(negedge clk);
      dividend = 1000; divisor = 10; start = 1'b1;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!done && lat < 100);
      chk("b2b first q", quotient, 100);
      chk("b2b first r", remainder, 0);
      dividend = 999; divisor = 10;
      @(negedge clk);
      chk("b2b idle gap busy", W'(busy), 0);
      @(negedge clk);
      chk("b2b second accepted", W'(busy), 1);
      start = 1'b0;
      lat = 2;
      while (!done && lat < 100) begin @(negedge clk); lat++; end
      chk("b2b done interval", W'(lat), 34);
      chk("b2b second q", quotient, 99);
      chk("b2b second r", remainder, 9);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
